tc_scan_scheduler: RTL and testbench

Round-robin conversion scheduler that shares one SPI master among `NCH` MAX31855-style thermocouple converters. It waits for converter power-up, then selects each enabled channel in turn and drives the SPI master's `spi_ena`/`spi_not_busy` handshake. It splits each 32-bit frame into thermocouple, junction and fault fields and emits one tagged result per conversion. It sits between the SPI master and the temperature consumers.

---
 rtl/tc_scan_scheduler.sv | 143 ++++++++++++++
 tb/tb_tc_scan_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_scan_scheduler.sv
// tc_scan_scheduler: round-robin scan of NCH MAX31855-style converters over one shared SPI master.
// Build option: define TC_FAULT_SKIP_EN to skip channels whose fault_sticky bit is set.
module tc_scan_scheduler #(
  parameter int NCH = 4,
  parameter int CLK_FREQ = 200,
  parameter int STARTUP_UNITS = 3,
  parameter int GAP_UNITS = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           ch_enable,
  input  logic                     fault_clr,
  input  logic                     spi_not_busy,
  input  logic [31:0]              spi_rx_data,
  output logic                     spi_ena,
  output logic [NCH-1:0]           spi_cs_n,
  output logic                     res_valid,
  output logic [$clog2(NCH)-1:0]   res_ch,
  output logic [13:0]              res_tc_temp,
  output logic [11:0]              res_jn_temp,
  output logic [3:0]               res_fault,
  output logic [NCH-1:0]           fault_sticky,
  output logic                     scan_done
);
  localparam int STARTUP = CLK_FREQ * STARTUP_UNITS;
  localparam int GAP = CLK_FREQ * GAP_UNITS;
  localparam int CW = $clog2((STARTUP > GAP ? STARTUP : GAP) + 1);
  localparam int CHW = $clog2(NCH);

  typedef enum logic [2:0] {ST_STARTUP, ST_PICK, ST_REQ, ST_BUSY, ST_GAP} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [CHW-1:0]   ptr, ptr_n, cur_ch, cur_n, off, pick;
  logic [CHW:0]     sum;
  logic [NCH-1:0]   en_q, en_n, cand, skip, cs_nx;
  logic [2*NCH-1:0] rot;
  logic             ena_n, cap, found, later;

`ifdef TC_FAULT_SKIP_EN
  assign skip = fault_sticky;
`else
  assign skip = '0;
`endif

  // Rotate the candidate mask so the pointer sits at bit 0; the lowest set bit is the next channel.
  always_comb begin
    cand = ch_enable & ~skip;
    rot = {cand, cand} >> ptr;
    found = 1'b0;
    off = '0;
    later = 1'b0;
    for (int i = NCH - 1; i >= 0; i--)
      if (rot[i]) begin
        found = 1'b1;
        off = CHW'(i);
      end
    for (int i = 0; i < NCH; i++)
      if (i > int'(cur_ch) && en_q[i] && !skip[i]) later = 1'b1;
    sum = {1'b0, ptr} + {1'b0, off};
    pick = (sum >= (CHW+1)'(NCH)) ? CHW'(sum - (CHW+1)'(NCH)) : CHW'(sum);
  end

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ptr_n = ptr;
    cur_n = cur_ch;
    en_n = en_q;
    ena_n = spi_ena;
    cs_nx = spi_cs_n;
    cap = 1'b0;
    case (state)
      ST_STARTUP: begin
        cnt_n = (cnt == CW'(STARTUP - 1)) ? '0 : cnt + 1'b1;
        state_n = (cnt == CW'(STARTUP - 1)) ? ST_PICK : ST_STARTUP;
      end
      ST_PICK: if (found) begin
        state_n = ST_REQ;
        cur_n = pick;
        en_n = ch_enable;
        cs_nx = ~(NCH'(1) << pick);
      end
      ST_REQ: begin
        ena_n = spi_not_busy;
        state_n = spi_not_busy ? ST_REQ : ST_BUSY;
      end
      ST_BUSY: if (spi_not_busy) begin
        cap = 1'b1;
        cs_nx = '1;
        ptr_n = (cur_ch == CHW'(NCH - 1)) ? '0 : cur_ch + 1'b1;
        cnt_n = '0;
        state_n = ST_GAP;
      end
      ST_GAP: begin
        cnt_n = (cnt == CW'(GAP - 1)) ? '0 : cnt + 1'b1;
        state_n = (cnt == CW'(GAP - 1)) ? ST_PICK : ST_GAP;
      end
      default: begin
        state_n = ST_PICK;
        cnt_n = '0;
        ena_n = 1'b0;
        cs_nx = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STARTUP;
      cnt <= '0;
      ptr <= '0;
      cur_ch <= '0;
      en_q <= '0;
      spi_ena <= 1'b0;
      spi_cs_n <= '1;
      res_valid <= 1'b0;
      res_ch <= '0;
      res_tc_temp <= '0;
      res_jn_temp <= '0;
      res_fault <= '0;
      fault_sticky <= '0;
      scan_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
      cur_ch <= cur_n;
      en_q <= en_n;
      spi_ena <= ena_n;
      spi_cs_n <= cs_nx;
      res_valid <= cap;
      scan_done <= cap & ~later;
      fault_sticky <= (fault_clr ? '0 : fault_sticky) | ((cap && spi_rx_data[16]) ? (NCH'(1) << cur_ch) : '0);
      if (cap) begin
        res_ch <= cur_ch;
        res_tc_temp <= spi_rx_data[31:18];
        res_jn_temp <= spi_rx_data[15:4];
        res_fault <= {spi_rx_data[16], spi_rx_data[2:0]};
      end
    end
  end
endmodule

// File: tb/tb_tc_scan_scheduler.sv
// tb_tc_scan_scheduler: directed scenarios against a round-robin result model plus a busy-5 SPI master model.
module tb_tc_scan_scheduler;
  logic        clk, rst_n, fault_clr, spi_not_busy, spi_ena, res_valid, scan_done;
  logic [3:0]  ch_enable, spi_cs_n, res_fault, fault_sticky;
  logic [31:0] spi_rx_data;
  logic [1:0]  res_ch;
  logic [13:0] res_tc_temp;
  logic [11:0] res_jn_temp;

  tc_scan_scheduler #(.NCH(4), .CLK_FREQ(4), .STARTUP_UNITS(3), .GAP_UNITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ch_enable(ch_enable), .fault_clr(fault_clr),
    .spi_not_busy(spi_not_busy), .spi_rx_data(spi_rx_data), .spi_ena(spi_ena),
    .spi_cs_n(spi_cs_n), .res_valid(res_valid), .res_ch(res_ch), .res_tc_temp(res_tc_temp),
    .res_jn_temp(res_jn_temp), .res_fault(res_fault), .fault_sticky(fault_sticky),
    .scan_done(scan_done));

  int n_chk = 0, n_fail = 0, bcnt, cs02_low;
  logic [31:0] frames [4];
  int log_ch[$];
  bit log_done[$];
  logic clr_q = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) clr_q <= fault_clr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int act_ch(input logic [3:0] cs);
    for (int k = 0; k < 4; k++) if (!cs[k]) return k;
    return 0;
  endfunction

  function automatic int next_ch(input int p, input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  // SPI master: accepts spi_ena while idle, stays busy 5 cycles, returns the frame of the selected channel.
  initial begin
    spi_not_busy = 1'b1;
    spi_rx_data = '0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        spi_not_busy = 1'b1;
        bcnt = 0;
      end else if (!spi_not_busy) begin
        bcnt--;
        if (bcnt == 0) spi_not_busy = 1'b1;
      end else if (spi_ena) begin
        spi_not_busy = 1'b0;
        bcnt = 5;
        spi_rx_data = frames[act_ch(spi_cs_n)];
      end
    end
  end

  // Result model: expected channel order, field split, scan_done and sticky faults.
  initial begin
    logic [3:0] fs_m, fs_prev, avail;
    logic [31:0] fr, er_ch, er_tc, er_jn, er_f;
    int ptr_m, ec;
    bit ed;
    fs_m = '0; ptr_m = 0; er_ch = 0; er_tc = 0; er_jn = 0; er_f = 0; cs02_low = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fs_m = '0; ptr_m = 0; er_ch = 0; er_tc = 0; er_jn = 0; er_f = 0;
        chk("rst_spi_ena", spi_ena, 0);
        chk("rst_cs_n", spi_cs_n, 4'hf);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_fault_sticky", fault_sticky, 0);
      end else begin
        fs_prev = fs_m;
        if (clr_q) fs_m = '0;
`ifdef TC_FAULT_SKIP_EN
        avail = ch_enable & ~fs_prev;
`else
        avail = ch_enable;
`endif
        if (res_valid) begin
          ec = next_ch(ptr_m, avail);
          fr = frames[ec < 0 ? 0 : ec];
          er_ch = ec;
          er_tc = fr >> 18;
          er_jn = (fr >> 4) & 32'hfff;
          er_f = {fr[16], fr[2:0]};
          ed = 1'b1;
          for (int k = ec + 1; k < 4; k++) if (avail[k]) ed = 1'b0;
          chk("scan_done", scan_done, ed);
          if (fr[16]) fs_m[ec] = 1'b1;
          ptr_m = (ec + 1) % 4;
          log_ch.push_back(ec);
          log_done.push_back(scan_done);
        end else
          chk("scan_done_idle", scan_done, 0);
        chk("res_ch", res_ch, er_ch);
        chk("res_tc_temp", res_tc_temp, er_tc);
        chk("res_jn_temp", res_jn_temp, er_jn);
        chk("res_fault", res_fault, er_f);
        chk("fault_sticky", fault_sticky, fs_m);
        chk("cs_shape", spi_cs_n == 4'hf || $onehot(~spi_cs_n), 1);
        chk("cs_enabled", |(~spi_cs_n & ~ch_enable), 0);
        if (spi_ena) chk("ena_with_cs", spi_cs_n != 4'hf, 1);
        if (!spi_cs_n[0] || !spi_cs_n[2]) cs02_low++;
      end
    end
  end

  task automatic wait_res(input int n, input string name);
    int t = 0;
    while (log_ch.size() < n && t < 1000) begin
      @(negedge clk); #2;
      t++;
    end
    chk(name, log_ch.size(), n);
  endtask

  task automatic wait_nb(input logic v, input string name);
    int t = 0;
    while (spi_not_busy !== v && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    if (spi_not_busy !== v) chk(name, spi_not_busy, v);
  endtask

  task automatic first_ena(input logic [3:0] exp_cs, input string tag);
    int cyc = 0;
    logic [3:0] cs_pre = 4'hf;
    while (!spi_ena && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 13) cs_pre = spi_cs_n;
    end
    chk({tag, "_first_ena_cycle"}, cyc, 14);
    chk({tag, "_cs_before_ena"}, cs_pre, exp_cs);
  endtask

  task automatic clear_logs();
    log_ch.delete();
    log_done.delete();
  endtask

  initial begin
    logic [31:0] seq, dn;
    int ena_cnt, cs_low;
    rst_n = 1'b0; fault_clr = 1'b0; ch_enable = 4'hf;
    for (int i = 0; i < 4; i++) frames[i] = 32'h1900_1910;
    repeat (3) @(negedge clk);
    #1;
    chk("t1_reset_cs", spi_cs_n, 4'hf);
    chk("t1_reset_ena", spi_ena, 0);
    @(negedge clk);
    rst_n = 1'b1;
    first_ena(4'b1110, "t1");
    wait_res(5, "t1_results");
    seq = 0; dn = 0;
    foreach (log_ch[i]) begin seq = (seq << 4) | 32'(log_ch[i]); dn = (dn << 1) | 32'(log_done[i]); end
    chk("t1_order", seq, 32'h01230);
    chk("t1_scan_done", dn, 32'b00010);
    chk("t1_tc_literal", res_tc_temp, 14'h0640);
    chk("t1_jn_literal", res_jn_temp, 12'h191);

    ch_enable = 4'b1010;
    frames[1] = 32'h1234_5678;
    frames[3] = 32'hABCC_0FF8;
    clear_logs();
    cs02_low = 0;
    wait_res(4, "t2_results");
    seq = 0; dn = 0;
    foreach (log_ch[i]) begin seq = (seq << 4) | 32'(log_ch[i]); dn = (dn << 1) | 32'(log_done[i]); end
    chk("t2_order", seq, 32'h1313);
    chk("t2_scan_done", dn, 32'b0101);
    chk("t2_cs02_low_cycles", cs02_low, 0);

    ch_enable = 4'b0100;
    frames[2] = 32'h3FFD_5671;
    clear_logs();
    wait_nb(1'b0, "t3_busy_timeout");
    wait_nb(1'b1, "t3_done_timeout");
    fault_clr = 1'b1;
    @(negedge clk); #1;
    fault_clr = 1'b0;
    chk("t3_res_ch", res_ch, 2);
    chk("t3_res_fault", res_fault, 4'b1001);
    chk("t3_set_beats_clr", fault_sticky, 4'b0100);
    chk("t3_tc_literal", res_tc_temp, 14'h0fff);
    @(negedge clk); #1;
    fault_clr = 1'b1;
    frames[2] = 32'h0A00_1230;
    @(negedge clk); #1;
    fault_clr = 1'b0;
    chk("t3_cleared", fault_sticky, 4'b0000);
    wait_res(2, "t3_resume");

    wait_nb(1'b0, "t4_busy_timeout");
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_ena", spi_ena, 0);
    chk("t4_async_cs", spi_cs_n, 4'hf);
    chk("t4_async_valid", res_valid, 0);
    clear_logs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    first_ena(4'b1011, "t4");
    chk("t4_no_result", log_ch.size(), 0);

    @(negedge clk);
    rst_n = 1'b0;
    ch_enable = 4'b0000;
    clear_logs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ena_cnt = 0; cs_low = 0;
    repeat (30) begin
      @(negedge clk);
      if (spi_ena) ena_cnt++;
      if (spi_cs_n != 4'hf) cs_low++;
    end
    chk("t5_idle_ena", ena_cnt, 0);
    chk("t5_idle_cs", cs_low, 0);
    #1 ch_enable = 4'b0100;
    @(negedge clk);
    chk("t5_cs_after_1", spi_cs_n, 4'b1011);
    chk("t5_ena_after_1", spi_ena, 0);
    @(negedge clk);
    chk("t5_ena_after_2", spi_ena, 1);
    wait_res(1, "t5_result");

`ifdef TC_FAULT_SKIP_EN
    frames[2] = 32'h0001_0000;
    frames[3] = 32'h0001_0000;
    ch_enable = 4'b1100;
    clear_logs();
    wait_res(2, "t6_results");
    chk("t6_order", (32'(log_ch[0]) << 4) | 32'(log_ch[1]), 32'h32);
    ena_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (spi_ena) ena_cnt++;
    end
    chk("t6_all_faulted_idle", ena_cnt, 0);
    #1 fault_clr = 1'b1;
    @(negedge clk); #1;
    fault_clr = 1'b0;
    wait_res(3, "t6_resume");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
